// File: rtl/multicycle_cpu.sv
// multicycle_cpu: RV32I-subset core running one instruction per FETCH/EXEC/[MEM]/WB pass over req/ack memories
module multicycle_cpu #(
  parameter int INSN_ADDR_WIDTH = 11,
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC = 0,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  output logic [INSN_ADDR_WIDTH-1:0] insnAddr,
  output logic insnReq,
  input  logic insnAck,
  input  logic [31:0] insn,
  output logic [DATA_ADDR_WIDTH-1:0] dataAddr,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic dataWrEnable,
  output logic dataReq,
  input  logic dataAck,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic haltReq,
  output logic halted,
  output logic [RETIRE_CNT_WIDTH-1:0] retireCount
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} stateType;
  stateType state;
  logic [INSN_ADDR_WIDTH-1:0] pc, pcPlus4, pcNext;
  logic [31:0] ir, imm;
  logic [DATA_WIDTH-1:0] rf [0:31];
  logic [DATA_WIDTH-1:0] immX, rs1v, rs2v, aluB, aluY, aluRes, mdr, wbVal;
  logic signed [DATA_WIDTH-1:0] sraRes;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2, shamt;
  logic [2:0] f3;
  logic f7b5, isOp, isOpImm, isLoad, isStore, isBranch, isJump, isALUInImm, regWrEnable;
  logic eq, lt, ltu, brTaken, brTakenR;
  assign opcode = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7b5 = ir[30];
  assign isOp = opcode == 7'b0110011;
  assign isOpImm = opcode == 7'b0010011;
  assign isLoad = opcode == 7'b0000011;
  assign isStore = opcode == 7'b0100011;
  assign isBranch = opcode == 7'b1100011;
  assign isJump = opcode == 7'b1101111;
  assign isALUInImm = isOpImm;
  assign regWrEnable = isOp | isOpImm | isLoad | isJump;
  assign imm = isStore ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
               isBranch ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
               isJump ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
               {{20{ir[31]}}, ir[31:20]};
  assign immX = DATA_WIDTH'($signed(imm));
  assign rs1v = rs1 == 5'd0 ? '0 : rf[rs1];
  assign rs2v = rs2 == 5'd0 ? '0 : rf[rs2];
  // Branches compare rs1 against aluB, which is rs2 for them, so SLT and Bxx share comparators
  assign aluB = isALUInImm ? immX : (isOp && f3 == 3'b000 && f7b5) ? -rs2v : rs2v;
  assign shamt = aluB[4:0];
  assign eq = rs1v == aluB;
  assign lt = $signed(rs1v) < $signed(aluB);
  assign ltu = rs1v < aluB;
  assign sraRes = $signed(rs1v) >>> shamt;
  assign aluY = f3 == 3'b000 ? rs1v + aluB :
                f3 == 3'b001 ? rs1v << shamt :
                f3 == 3'b010 ? DATA_WIDTH'(lt) :
                f3 == 3'b011 ? DATA_WIDTH'(ltu) :
                f3 == 3'b100 ? rs1v ^ aluB :
                f3 == 3'b101 ? (f7b5 ? sraRes : rs1v >> shamt) :
                f3 == 3'b110 ? rs1v | aluB : rs1v & aluB;
  assign brTaken = f3[2:1] == 2'b01 ? 1'b0 : ((f3[2] ? (f3[1] ? ltu : lt) : eq) ^ f3[0]);
  assign pcPlus4 = pc + INSN_ADDR_WIDTH'(4);
  assign pcNext = (isJump || (isBranch && brTakenR)) ? pc + INSN_ADDR_WIDTH'(imm) : pcPlus4;
  assign wbVal = isJump ? DATA_WIDTH'(pcPlus4) : isLoad ? mdr : aluRes;
  // Requests are dropped combinationally under reset so a pending transfer is abandoned at once
  assign insnAddr = pc;
  assign insnReq = state == FETCH && !rst;
  assign dataReq = state == MEM && !rst;
  assign dataWrEnable = dataReq && isStore;
  assign halted = state == HALT && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= INSN_ADDR_WIDTH'(RESET_PC);
      retireCount <= '0;
      ir <= '0;
    end else begin
      case (state)
        FETCH: if (insnAck) begin
          ir <= insn;
          state <= EXEC;
        end
        EXEC: begin
          aluRes <= aluY;
          brTakenR <= brTaken;
          dataAddr <= DATA_ADDR_WIDTH'(rs1v + immX);
          dataOut <= rs2v;
          state <= (isLoad || isStore) ? MEM : WB;
        end
        MEM: if (dataAck) begin
          if (isLoad) mdr <= dataIn;
          state <= WB;
        end
        WB: begin
          if (regWrEnable && rd != 5'd0) rf[rd] <= wbVal;
          pc <= pcNext;
          retireCount <= retireCount + 1'b1;
          state <= haltReq ? HALT : FETCH;
        end
        HALT: if (!haltReq) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed program with a bench-side instruction/data memory and hand-computed results
module tb_multicycle_cpu;
  logic clk = 0, rst = 1;
  logic [10:0] insnAddr;
  logic insnReq, insnAck = 0;
  logic [31:0] insn = 0;
  logic [15:0] dataAddr;
  logic [31:0] dataOut, dataIn = 0, retireCount;
  logic dataWrEnable, dataReq, dataAck = 0, haltReq = 0, halted;
  int checks = 0, errors = 0;
  int reqCycles, wrAcks, cyc;
  logic [15:0] memAddr;
  logic [31:0] memOut;
  logic addrMoved, wrSeen;

  multicycle_cpu dut (
    .clk(clk), .rst(rst), .insnAddr(insnAddr), .insnReq(insnReq), .insnAck(insnAck), .insn(insn),
    .dataAddr(dataAddr), .dataOut(dataOut), .dataWrEnable(dataWrEnable), .dataReq(dataReq),
    .dataAck(dataAck), .dataIn(dataIn), .haltReq(haltReq), .halted(halted), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Serves one fetch at pcExp, then acts as data memory (ack after dWait request cycles) until the next fetch or halt
  task automatic runInsn(input logic [31:0] ins, input logic [10:0] pcExp, input int dWait,
                         input logic [31:0] dIn, input string tag);
    check({tag, ".insnReq"}, 32'(insnReq), 32'd1);
    check({tag, ".insnAddr"}, 32'(insnAddr), 32'(pcExp));
    insn = ins;
    insnAck = 1;
    cyc = 0;
    reqCycles = 0;
    wrAcks = 0;
    addrMoved = 0;
    wrSeen = 0;
    memAddr = 0;
    memOut = 0;
    @(negedge clk);
    insnAck = 0;
    insn = 0;
    cyc = 1;
    while (!insnReq && !halted && cyc < 40) begin
      if (dataReq) begin
        reqCycles++;
        if (reqCycles == 1) memAddr = dataAddr;
        else if (dataAddr !== memAddr) addrMoved = 1;
        if (dataWrEnable) wrSeen = 1;
        if (reqCycles > dWait) begin
          dataAck = 1;
          dataIn = dIn;
          if (dataWrEnable) begin
            wrAcks++;
            memOut = dataOut;
          end
        end
      end
      @(negedge clk);
      dataAck = 0;
      cyc++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.insnReq", 32'(insnReq), 0);
    check("rst.dataReq", 32'(dataReq), 0);
    check("rst.halted", 32'(halted), 0);
    check("rst.retire", retireCount, 0);
    rst = 0;
    #1;
    runInsn(32'h00500093, 11'h000, 0, 0, "addi");
    check("addi.cycles", 32'(cyc), 3);
    check("addi.x1", dut.rf[1], 32'd5);
    check("addi.retire", retireCount, 1);
    runInsn(32'h00108133, 11'h004, 0, 0, "add");
    check("add.x2", dut.rf[2], 32'd10);
    runInsn(32'h401001B3, 11'h008, 0, 0, "sub");
    check("sub.x3", dut.rf[3], 32'hFFFFFFFB);
    runInsn(32'h0080A203, 11'h00C, 3, 32'hCAFEBABE, "lw");
    check("lw.cycles", 32'(cyc), 7);
    check("lw.reqCycles", 32'(reqCycles), 4);
    check("lw.dataAddr", 32'(memAddr), 32'h000D);
    check("lw.addrMoved", 32'(addrMoved), 0);
    check("lw.wrSeen", 32'(wrSeen), 0);
    check("lw.x4", dut.rf[4], 32'hCAFEBABE);
    runInsn(32'h00202023, 11'h010, 0, 0, "sw");
    check("sw.cycles", 32'(cyc), 4);
    check("sw.reqCycles", 32'(reqCycles), 1);
    check("sw.wrAcks", 32'(wrAcks), 1);
    check("sw.dataOut", memOut, 32'd10);
    check("sw.dataAddr", 32'(memAddr), 0);
    check("sw.x4kept", dut.rf[4], 32'hCAFEBABE);
    runInsn(32'hFE000CE3, 11'h014, 0, 0, "beqTaken");
    check("beq.cycles", 32'(cyc), 3);
    runInsn(32'hFE001CE3, 11'h00C, 0, 0, "bneNotTaken");
    runInsn(32'h0100006F, 11'h010, 0, 0, "jalX0");
    runInsn(32'h010000EF, 11'h020, 0, 0, "jalX1");
    check("jal.x1", dut.rf[1], 32'h24);
    runInsn(32'h7CC0006F, 11'h030, 0, 0, "jalFar");
    runInsn(32'h0080006F, 11'h7FC, 0, 0, "jalWrap");
    haltReq = 1;
    runInsn(32'hFFF00293, 11'h004, 0, 0, "addiHalt");
    check("halt.cycles", 32'(cyc), 3);
    check("halt.halted", 32'(halted), 1);
    check("halt.x5", dut.rf[5], 32'hFFFFFFFF);
    check("halt.retire", retireCount, 12);
    repeat (3) @(negedge clk);
    check("halt.insnReq", 32'(insnReq), 0);
    check("halt.stillHalted", 32'(halted), 1);
    check("halt.pcHeld", 32'(insnAddr), 32'h008);
    haltReq = 0;
    @(negedge clk);
    check("resume.halted", 32'(halted), 0);
    runInsn(32'h0000028B, 11'h008, 0, 0, "unknown");
    check("unknown.x5", dut.rf[5], 32'hFFFFFFFF);
    runInsn(32'h00700013, 11'h00C, 0, 0, "addiX0");
    runInsn(32'h00100333, 11'h010, 0, 0, "addX0");
    check("x0.reads0", dut.rf[6], 32'h24);
    check("retire.15", retireCount, 15);
    check("lwRst.insnAddr", 32'(insnAddr), 32'h014);
    insn = 32'h00002303;
    insnAck = 1;
    @(negedge clk);
    insnAck = 0;
    insn = 0;
    @(negedge clk);
    check("lwRst.dataReq", 32'(dataReq), 1);
    rst = 1;
    #1;
    check("lwRst.dropReq", 32'(dataReq), 0);
    check("lwRst.dropWr", 32'(dataWrEnable), 0);
    @(negedge clk);
    check("lwRst.insnReq", 32'(insnReq), 0);
    check("lwRst.retire", retireCount, 0);
    check("lwRst.x6", dut.rf[6], 32'h24);
    rst = 0;
    #1;
    check("lwRst.fetch", 32'(insnReq), 1);
    check("lwRst.pc", 32'(insnAddr), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
